gpio_reg_arbiter: RTL and testbench

- Two-requester round-robin arbiter and access sequencer for the GPIO register block.
- Port 0 is the host/CPU bus; port 1 is the debug/DMA bus.
- Latches one requester's command, drives the register block's addr/wben/r_wn/wdata for exactly one cycle, captures rdata after a configurable read latency, and returns a one-cycle ack.
- Sits between the bus front-ends and the register block, which remains the only owner of rf_gpio_* state.

---
 rtl/gpio_pkg.sv | 27 ++
 rtl/gpio_reg_arbiter_if.sv | 39 +++
 rtl/gpio_rr_pick.sv | 26 ++
 rtl/gpio_reg_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_gpio_reg_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO register arbiter: FSM encoding, register
// word addresses, default bus width and the latched command record.
package gpio_pkg;

  localparam int GPIO_DATA_W = 32;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_WAIT   = 2'd2;
  localparam logic [1:0] ARB_RESP   = 2'd3;

  localparam logic [4:2] DATAREG  = 3'd0;
  localparam logic [4:2] TRISTATE = 3'd1;
  localparam logic [4:2] INT_MASK = 3'd2;
  localparam logic [4:2] PINSTATE = 3'd3;

  typedef struct packed {
    logic       r_wn;
    logic [4:2] addr;
    logic [3:0] wben;
  } reg_cmd_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gpio_reg_arbiter_if.sv
// Bus bundle between the two requester front-ends, the arbiter and the GPIO
// register block; slave is the arbiter's view, master the surrounding system.
interface gpio_reg_arbiter_if
  import gpio_pkg::*;
#(
  parameter int DATA_W = GPIO_DATA_W
);

  logic              req0,   req1;
  logic              r_wn0,  r_wn1;
  logic [4:2]        addr0,  addr1;
  logic [3:0]        wben0,  wben1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              lock0,  lock1;
  logic              ack0,   ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [1:0]        gnt;

  logic [4:2]        reg_addr;
  logic [3:0]        reg_wben;
  logic              reg_r_wn;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;

  modport slave (
    input  req0, req1, r_wn0, r_wn1, addr0, addr1, wben0, wben1,
           wdata0, wdata1, lock0, lock1, reg_rdata,
    output ack0, ack1, rdata0, rdata1, gnt,
           reg_addr, reg_wben, reg_r_wn, reg_wdata
  );

  modport master (
    output req0, req1, r_wn0, r_wn1, addr0, addr1, wben0, wben1,
           wdata0, wdata1, lock0, lock1, reg_rdata,
    input  ack0, ack1, rdata0, rdata1, gnt,
           reg_addr, reg_wben, reg_r_wn, reg_wdata
  );

endinterface

// File: rtl/gpio_rr_pick.sv
// Combinational two-way winner selector: a pending lock hold beats round-robin,
// otherwise contention goes to the port that did not hold last_gnt.
module gpio_rr_pick
  import gpio_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       lock_hold,
  input  logic       lock_owner,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    if (lock_hold && req[lock_owner]) begin
      win = port_onehot(lock_owner);
    end else if (req == 2'b11) begin
      win = port_onehot(~last_gnt);
    end else if (req[0]) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end
  end

endmodule

// File: rtl/gpio_reg_arbiter.sv
// Two-port round-robin arbiter and single-cycle access sequencer for the GPIO
// register block. Define GPIO_ARB_LOCK_EN to honour lock0/lock1 (bounded by LOCK_MAX).
module gpio_reg_arbiter
  import gpio_pkg::*;
#(
  parameter int DATA_W   = GPIO_DATA_W,
  parameter int RD_LAT   = 0,
  parameter int LOCK_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  gpio_reg_arbiter_if.slave   bus
);

  if (RD_LAT < 0 || RD_LAT > 3) begin : g_rd_lat_chk
    $error("gpio_reg_arbiter: RD_LAT must be in 0..3");
  end

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT > 0 ? RD_LAT - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic [4:2]        reg_addr_q, reg_addr_d;
  logic [3:0]        reg_wben_q, reg_wben_d;
  logic              reg_r_wn_q, reg_r_wn_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;

  logic [1:0]        win;
  logic              lock_hold;
  logic              lock_owner;
  reg_cmd_t          sel_cmd;
  logic [DATA_W-1:0] sel_wdata;
  logic              finish;
  logic              capture;

  gpio_rr_pick u_pick (
    .req        ({bus.req1, bus.req0}),
    .last_gnt   (last_gnt_q),
    .lock_hold  (lock_hold),
    .lock_owner (lock_owner),
    .win        (win)
  );

`ifdef GPIO_ARB_LOCK_EN
  localparam int             CNT_W    = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

  logic             lock_pend_q, lock_pend_d;
  logic             lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  assign lock_hold  = lock_pend_q && (lock_cnt_q < LOCK_LIM);
  assign lock_owner = lock_owner_q;

  // The lock request is sampled in RESP; the hold is consumed by the next grant.
  always_comb begin
    lock_pend_d  = lock_pend_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    if (state_q == ARB_IDLE && win != 2'b00) begin
      lock_pend_d = 1'b0;
      if (lock_hold && win == port_onehot(lock_owner_q)) begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
      end else begin
        lock_cnt_d = '0;
      end
    end else if (state_q == ARB_RESP) begin
      lock_pend_d  = gnt_q[1] ? bus.lock1 : bus.lock0;
      lock_owner_d = gnt_q[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_pend_q  <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      lock_pend_q  <= lock_pend_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end
`else
  localparam int unused_lock_max = LOCK_MAX;
  wire           unused_lock     = ^{bus.lock0, bus.lock1};

  assign lock_hold  = 1'b0;
  assign lock_owner = 1'b0;
`endif

  always_comb begin
    if (win[1]) begin
      sel_cmd   = '{r_wn: bus.r_wn1, addr: bus.addr1, wben: bus.wben1};
      sel_wdata = bus.wdata1;
    end else begin
      sel_cmd   = '{r_wn: bus.r_wn0, addr: bus.addr0, wben: bus.wben0};
      sel_wdata = bus.wdata0;
    end
  end

  // Main sequencer; reg_wben can only be nonzero while ACCESS is the next state.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    reg_addr_d  = reg_addr_q;
    reg_wben_d  = reg_wben_q;
    reg_r_wn_d  = reg_r_wn_q;
    reg_wdata_d = reg_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    wait_cnt_d  = wait_cnt_q;
    finish      = 1'b0;
    capture     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (win != 2'b00) begin
          gnt_d       = win;
          reg_addr_d  = sel_cmd.addr;
          reg_r_wn_d  = sel_cmd.r_wn;
          reg_wben_d  = sel_cmd.r_wn ? 4'h0 : sel_cmd.wben;
          reg_wdata_d = sel_wdata;
          state_d     = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        reg_wben_d = 4'h0;
        if (!reg_r_wn_q) begin
          finish = 1'b1;
        end else if (RD_LAT == 0) begin
          capture = 1'b1;
          finish  = 1'b1;
        end else begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          capture = 1'b1;
          finish  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      ARB_RESP: begin
        gnt_d      = 2'b00;
        last_gnt_d = ~last_gnt_q;
        state_d    = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (finish) begin
      state_d    = ARB_RESP;
      reg_r_wn_d = 1'b1;
      reg_wben_d = 4'h0;
      ack0_d     = gnt_q[0];
      ack1_d     = gnt_q[1];
    end
    if (capture) begin
      if (gnt_q[0]) rdata0_d = bus.reg_rdata;
      if (gnt_q[1]) rdata1_d = bus.reg_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= 2'b00;
      last_gnt_q  <= 1'b1;
      reg_addr_q  <= '0;
      reg_wben_q  <= 4'h0;
      reg_r_wn_q  <= 1'b1;
      reg_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      wait_cnt_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      reg_addr_q  <= reg_addr_d;
      reg_wben_q  <= reg_wben_d;
      reg_r_wn_q  <= reg_r_wn_d;
      reg_wdata_q <= reg_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wben  = reg_wben_q;
  assign bus.reg_r_wn  = reg_r_wn_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Directed bench for gpio_reg_arbiter with RD_LAT=2 and a small register-file
// model; the lock scenario expects bursts only when GPIO_ARB_LOCK_EN is defined.
module tb_gpio_reg_arbiter;
  import gpio_pkg::*;

  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 2;
  localparam int LOCK_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] rf [0:7];

  gpio_reg_arbiter_if #(.DATA_W(DATA_W)) bus ();

  gpio_reg_arbiter #(
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for the register block: byte-enabled writes, combinational read.
  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
  end

  always @(posedge clk) begin
    if (!bus.reg_r_wn) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.reg_wben[b]) rf[bus.reg_addr][8*b +: 8] <= bus.reg_wdata[8*b +: 8];
      end
    end
  end

  assign bus.reg_rdata = rf[bus.reg_addr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit port, input bit rwn, input logic [4:2] addr,
                               input logic [3:0] wben, input logic [31:0] wdata, input bit lock);
    if (port) begin
      bus.r_wn1 = rwn; bus.addr1 = addr; bus.wben1 = wben; bus.wdata1 = wdata;
      bus.lock1 = lock; bus.req1 = 1'b1;
    end else begin
      bus.r_wn0 = rwn; bus.addr0 = addr; bus.wben0 = wben; bus.wdata0 = wdata;
      bus.lock0 = lock; bus.req0 = 1'b1;
    end
  endtask

  task automatic dropRequests();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0; bus.lock1 = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One single-port transaction: latency, grant, strobe count and both rdata ports.
  task automatic runTxn(input string tag, input bit port, input bit rwn, input logic [4:2] addr,
                        input logic [3:0] wben, input logic [31:0] wdata, input int expLat,
                        input int expPulses, input logic [31:0] expOwn, input logic [31:0] expOther,
                        input bit dropEarly);
    int lat = 0;
    int pulses = 0;
    bit seen = 0;
    logic [1:0] expGnt;
    expGnt = port ? 2'b10 : 2'b01;
    @(negedge clk);
    applyStimulus(port, rwn, addr, wben, wdata, 1'b0);
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput({tag, "_gnt"}, 32'(bus.gnt), 32'(expGnt));
        checkOutput({tag, "_addr"}, 32'(bus.reg_addr), 32'(addr));
        checkOutput({tag, "_wben"}, 32'(bus.reg_wben), rwn ? 32'h0 : 32'(wben));
        if (dropEarly) dropRequests();
      end
      if (bus.reg_wben != 4'h0) pulses++;
      if (bus.ack0 || bus.ack1) begin
        seen = 1;
        lat = k;
        checkOutput({tag, "_ack"}, 32'({bus.ack1, bus.ack0}), 32'(expGnt));
        checkOutput({tag, "_rdown"}, port ? bus.rdata1 : bus.rdata0, expOwn);
        checkOutput({tag, "_rdoth"}, port ? bus.rdata0 : bus.rdata1, expOther);
        checkOutput({tag, "_rwnresp"}, 32'(bus.reg_r_wn), 32'h1);
      end
    end
    dropRequests();
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_pulses"}, 32'(pulses), 32'(expPulses));
  endtask

  // Both ports request continuously; bit n of expOrder is the port of ack n.
  task automatic runContention(input string tag, input bit lockVal, input logic [5:0] expOrder);
    int n = 0;
    int lastK = 0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd4, 4'hF, 32'h0000_0044, lockVal);
    applyStimulus(1'b1, 1'b0, 3'd5, 4'hF, 32'h0000_0055, 1'b0);
    for (int k = 1; k <= 80 && n < 6; k++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        checkOutput($sformatf("%s_ack%0d", tag, n), 32'({bus.ack1, bus.ack0}),
                    expOrder[n] ? 32'h2 : 32'h1);
        if (n > 0) checkOutput($sformatf("%s_gap%0d", tag, n), 32'(k - lastK), 32'd3);
        lastK = k;
        n++;
      end
    end
    dropRequests();
    checkOutput({tag, "_count"}, 32'(n), 32'd6);
  endtask

  initial begin
    reset = 1'b0;
    bus.r_wn0 = 1'b0; bus.addr0 = '0; bus.wben0 = '0; bus.wdata0 = '0;
    bus.r_wn1 = 1'b0; bus.addr1 = '0; bus.wben1 = '0; bus.wdata1 = '0;
    dropRequests();

    repeat (3) @(negedge clk);
    checkOutput("rst_ack0", 32'(bus.ack0), 32'h0);
    checkOutput("rst_ack1", 32'(bus.ack1), 32'h0);
    checkOutput("rst_rdata0", bus.rdata0, 32'h0);
    checkOutput("rst_rdata1", bus.rdata1, 32'h0);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("rst_addr", 32'(bus.reg_addr), 32'h0);
    checkOutput("rst_wben", 32'(bus.reg_wben), 32'h0);
    checkOutput("rst_rwn", 32'(bus.reg_r_wn), 32'h1);
    checkOutput("rst_wdata", bus.reg_wdata, 32'h0);
    reset = 1'b1;

    runTxn("wr_data", 1'b0, 1'b0, DATAREG, 4'hF, 32'h0000_A5A5, 2, 1, 32'h0, 32'h0, 1'b0);
    checkOutput("rf_datareg", rf[0], 32'h0000_A5A5);
    runTxn("wr_tri", 1'b0, 1'b0, TRISTATE, 4'hF, 32'h0000_00FF, 2, 1, 32'h0, 32'h0, 1'b0);
    runTxn("rd_tri", 1'b1, 1'b1, TRISTATE, 4'h0, 32'h0, 2 + RD_LAT, 0, 32'h0000_00FF, 32'h0, 1'b0);
    runTxn("wr_nowben", 1'b1, 1'b0, INT_MASK, 4'h0, 32'hFFFF_FFFF, 2, 0,
           32'h0000_00FF, 32'h0, 1'b0);
    checkOutput("rf_intmask", rf[2], 32'h0);
    runTxn("rd_mask", 1'b0, 1'b1, DATAREG, 4'hF, 32'h0, 2 + RD_LAT, 0,
           32'h0000_A5A5, 32'h0000_00FF, 1'b0);
    runTxn("wr_drop", 1'b1, 1'b0, PINSTATE, 4'h3, 32'h1234_5678, 2, 1,
           32'h0000_00FF, 32'h0000_A5A5, 1'b1);
    checkOutput("rf_pinstate", rf[3], 32'h0000_5678);

    // Reset lands in the middle of the ACCESS cycle of a write.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, DATAREG, 4'hF, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checkOutput("mid_wben_pre", 32'(bus.reg_wben), 32'hF);
    reset = 1'b0;
    #1;
    checkOutput("mid_ack0", 32'(bus.ack0), 32'h0);
    checkOutput("mid_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("mid_wben", 32'(bus.reg_wben), 32'h0);
    dropRequests();
    @(negedge clk);
    checkOutput("mid_ack0_hold", 32'(bus.ack0), 32'h0);
    reset = 1'b1;
    checkOutput("rf_datareg_kept", rf[0], 32'h0000_A5A5);

    runContention("rr", 1'b0, 6'b101010);

    pulseReset();
`ifdef GPIO_ARB_LOCK_EN
    runContention("lock", 1'b1, 6'b100000);
`else
    runContention("lock", 1'b1, 6'b101010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
